// File: rtl/sin_400k_pkg.sv
// Shared constants, quadrant type and quarter-wave table generator for the sin_400k NCO.
// The table function is evaluated at elaboration only, to fill the ROM contents.
package sin_400k_pkg;

  localparam int PHASE_W       = 32;
  localparam int PHASE_TRUNC_W = 12;
  localparam int OUT_W         = 14;
  localparam int AMPL          = 8191;
  localparam int LATENCY       = 4;
  localparam int TABLE_DEPTH   = 1025;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

  // round(AMPL * sin(pi*n/2048)); the argument stays in the first quadrant, so +0.5 rounds correctly
  function automatic logic [12:0] qsin(input int n);
    real x;
    x = real'(AMPL) * $sin(3.14159265358979323846 * real'(n) / 2048.0) + 0.5;
    return 13'($rtoi(x));
  endfunction

  function automatic logic [OUT_W-1:0] apply_sign(input logic [12:0] mag, input logic neg);
    logic [OUT_W-1:0] ext;
    ext = {1'b0, mag};
    return neg ? (~ext + 14'd1) : ext;
  endfunction

endpackage

// File: rtl/sin_400k_qrom.sv
// Dual-read quarter-wave sine ROM with registered outputs (1 enabled cycle of latency).
// Both ports read in the same cycle; addresses never exceed 1024 by construction upstream.
module sin_400k_qrom
  import sin_400k_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clken,
  input  logic [10:0] addr_a,
  input  logic [10:0] addr_b,
  output logic [12:0] data_a,
  output logic [12:0] data_b
);

  logic [12:0] rom [0:TABLE_DEPTH-1];

  for (genvar g = 0; g < TABLE_DEPTH; g++) begin : g_rom
    localparam logic [12:0] VAL = qsin(g);
    assign rom[g] = VAL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_a <= '0;
      data_b <= '0;
    end else if (clken) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/sin_400k.sv
// Quadrature NCO: 32-bit phase accumulator, 12-bit truncation, quarter-wave ROM, 4-stage pipeline.
// Define SIN_400K_PHASE_DITHER_EN to add 20-bit LFSR dither to acc[19:12] before truncation.
module sin_400k
  import sin_400k_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clken,
  input  logic [PHASE_W-1:0]   phi_inc_i,
  output logic [OUT_W-1:0]     fsin_o,
  output logic [OUT_W-1:0]     fcos_o,
  output logic                 out_valid
);

  logic [PHASE_W-1:0]       acc;
  logic [PHASE_TRUNC_W-1:0] trunc;
  logic [PHASE_TRUNC_W-1:0] ph1;
  quad_t                    q2, q3;
  logic [10:0]              sin_addr, cos_addr;
  logic [12:0]              sin_mag, cos_mag;
  logic [2:0]               cnt;

`ifdef SIN_400K_PHASE_DITHER_EN
  logic [19:0]        lfsr;
  logic [PHASE_W-1:0] dith;
  logic               unused_dith;

  assign dith        = acc + {12'd0, lfsr[7:0], 12'd0};
  assign trunc       = dith[PHASE_W-1 -: PHASE_TRUNC_W];
  assign unused_dith = ^{dith[19:0], lfsr[19:8]};

  // x^20 + x^17 + 1, maximal length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   lfsr <= 20'h00001;
    else if (clken) lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
  end
`else
  logic unused_lsb;
  assign trunc      = acc[PHASE_W-1 -: PHASE_TRUNC_W];
  assign unused_lsb = ^acc[19:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      ph1      <= '0;
      q2       <= Q0;
      sin_addr <= '0;
      cos_addr <= '0;
      q3       <= Q0;
      fsin_o   <= '0;
      fcos_o   <= '0;
      cnt      <= '0;
      out_valid <= 1'b0;
    end else if (clken) begin
      acc <= acc + phi_inc_i;
      ph1 <= trunc;
      q2  <= quad_t'(ph1[11:10]);
      // odd quadrants read sine from the mirrored address
      sin_addr <= ph1[10] ? (11'd1024 - {1'b0, ph1[9:0]}) : {1'b0, ph1[9:0]};
      cos_addr <= ph1[10] ? {1'b0, ph1[9:0]} : (11'd1024 - {1'b0, ph1[9:0]});
      q3  <= q2;
      fsin_o <= apply_sign(sin_mag, q3 inside {Q2, Q3});
      fcos_o <= apply_sign(cos_mag, q3 inside {Q1, Q2});
      if (!out_valid) begin
        cnt <= cnt + 3'd1;
        if (cnt == 3'(LATENCY - 1)) out_valid <= 1'b1;
      end
    end
  end

  sin_400k_qrom u_qrom (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .addr_a  (sin_addr),
    .addr_b  (cos_addr),
    .data_a  (sin_mag),
    .data_b  (cos_mag)
  );

endmodule

// File: tb/tb_sin_400k.sv
// Self-checking bench for sin_400k: golden table model with a scoreboard queue of expected samples,
// a vector table for quarter-step outputs, and hand-written stall / async-reset / wrap sequences.
module tb_sin_400k;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic [31:0] phi_inc_i = '0;
  logic [13:0] fsin_o, fcos_o;
  logic        out_valid;

  sin_400k dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int c; } pair_t;
  typedef struct { logic [31:0] inc; int s; int c; } vec_t;

  int    lut [0:1024];
  pair_t sb_q [$];
  logic [31:0] model_acc;
  int    n_checks = 0;
  int    n_fail = 0;
  int    last_s, last_c;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pair_t golden(input logic [31:0] ph);
    logic [11:0] p;
    int i;
    pair_t r;
    p = ph[31:20];
    i = int'(p[9:0]);
    case (p[11:10])
      2'd0: begin r.s =  lut[i];        r.c =  lut[1024 - i]; end
      2'd1: begin r.s =  lut[1024 - i]; r.c = -lut[i];        end
      2'd2: begin r.s = -lut[i];        r.c = -lut[1024 - i]; end
      default: begin r.s = -lut[1024 - i]; r.c = lut[i];     end
    endcase
    return r;
  endfunction

  function automatic int s14(input logic [13:0] v);
    return int'($signed(v));
  endfunction

  // One clock; on enabled cycles the model accumulates and, once valid, the DUT output is scored.
  task automatic step(input logic en);
    clken = en;
    if (en) begin
      sb_q.push_back(golden(model_acc));
      model_acc = model_acc + phi_inc_i;
    end
    @(posedge clk);
    #1;
    if (en && out_valid) begin
      pair_t e;
      if (sb_q.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_sin", s14(fsin_o), e.s);
        check("sb_cos", s14(fcos_o), e.c);
      end
    end
    last_s = s14(fsin_o);
    last_c = s14(fcos_o);
  endtask

  task automatic clear_model();
    sb_q.delete();
    model_acc = '0;
  endtask

  task automatic sync_reset_seq(input logic [31:0] inc);
    reset_n = 1'b0;
    clken = 1'b0;
    phi_inc_i = inc;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t vt [8];
    int prev_neg, crossings, mx, mn;

    for (int n = 0; n <= 1024; n++)
      lut[n] = $rtoi(8191.0 * $sin(3.14159265358979323846 * real'(n) / 2048.0) + 0.5);

    vt[0] = '{32'h4000_0000,     0,  8191};
    vt[1] = '{32'h4000_0000,  8191,     0};
    vt[2] = '{32'h4000_0000,     0, -8191};
    vt[3] = '{32'h4000_0000, -8191,     0};
    vt[4] = '{32'h4000_0000,     0,  8191};
    vt[5] = '{32'h4000_0000,  8191,     0};
    vt[6] = '{32'h4000_0000,     0, -8191};
    vt[7] = '{32'h4000_0000, -8191,     0};

    // Reset held 7 cycles
    clear_model();
    phi_inc_i = 32'h00A7_C5AC;
    repeat (7) @(posedge clk);
    #1;
    check("rst_sin", s14(fsin_o), 0);
    check("rst_cos", s14(fcos_o), 0);
    check("rst_valid", int'(out_valid), 0);
    reset_n = 1'b1;

    // out_valid rises on the 4th enabled edge with the phase-0 sample
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      check("valid_rise", int'(out_valid), (k == 4) ? 1 : 0);
    end
    check("first_sin", last_s, 0);
    check("first_cos", last_c, 8191);

    // ~10 periods: sample 0 counts as the upward crossing at phase 0
    prev_neg = 1; crossings = 0; mx = -100000; mn = 100000;
    for (int k = 0; k < 3906; k++) begin
      if (k > 0) step(1'b1);
      if ((last_s < 0) != (prev_neg != 0)) crossings++;
      prev_neg = (last_s < 0) ? 1 : 0;
      if (last_s > mx) mx = last_s;
      if (last_s < mn) mn = last_s;
    end
    check("zero_crossings", crossings, 20);
    check("peak_le_8191", (mx <= 8191) ? 1 : 0, 1);
    check("trough_ge_m8191", (mn >= -8191) ? 1 : 0, 1);

    // Stall: everything frozen for 5 disabled cycles, then the sequence resumes without a gap
    begin
      int fs, fc;
      fs = last_s; fc = last_c;
      for (int k = 0; k < 5; k++) begin
        step(1'b0);
        check("stall_sin", last_s, fs);
        check("stall_cos", last_c, fc);
        check("stall_valid", int'(out_valid), 1);
      end
      repeat (20) step(1'b1);
    end

    // Asynchronous reset pulse between edges
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sin", s14(fsin_o), 0);
    check("arst_cos", s14(fcos_o), 0);
    check("arst_valid", int'(out_valid), 0);
    reset_n = 1'b1;
    clear_model();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      check("arst_valid_rise", int'(out_valid), (k == 4) ? 1 : 0);
    end
    check("arst_first_sin", last_s, 0);
    check("arst_first_cos", last_c, 8191);

    // Quarter steps from the vector table
    sync_reset_seq(vt[0].inc);
    repeat (3) step(1'b1);
    for (int k = 0; k < 8; k++) begin
      phi_inc_i = vt[k].inc;
      step(1'b1);
      check("qstep_valid", int'(out_valid), 1);
      check("qstep_sin", last_s, vt[k].s);
      check("qstep_cos", last_c, vt[k].c);
    end

    // Decrementing phase across the 2^32 wrap
    sync_reset_seq(32'hFFF0_0000);
    repeat (3000) step(1'b1);
    check("wrap_sb_depth", sb_q.size(), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
